stopwatch_bcd_ctrl: RTL and testbench

Upstream companion to the 4-digit seven-segment scan driver. Debounces two push-buttons, start/stop and clear, and runs a start/pause/clear state machine. Keeps a cascaded 4-digit BCD time count (SS.hh, 10 ms resolution, 00.00 to 99.99). Drives the packed BCD digits, a running flag and a sticky overflow flag; the scan driver multiplexes the digits onto the display.

---
 rtl/stopwatch_bcd_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_stopwatch_bcd_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_ctrl.sv
// stopwatch_bcd_ctrl
//   Stopwatch front end for the 4-digit seven-segment scan driver.
//   - Two debounced push-buttons: start/stop and clear.
//   - A start/pause/clear state machine.
//   - A cascaded 4-digit BCD time count, SS.hh, 10 ms resolution.
//
// Optional feature: define STOPWATCH_LAP_EN to add the lap key. A lap press
// while running freezes the displayed value. The live count keeps running
// underneath, and a second lap press shows the live count again.
//
// Parameters
//   TICK_DIV : clk_24m cycles per 10 ms count tick (2..2^20)
//   DEB_CNT  : cycles a synchronised key level must hold to be accepted (2..2^20)
//
// Ports
//   clk_24m     in   24 MHz system clock
//   rst_n       in   asynchronous active-low reset
//   key_start_n in   raw start/stop button, active-low, asynchronous
//   key_clr_n   in   raw clear button, active-low, asynchronous
//   key_lap_n   in   raw lap button, active-low, asynchronous (STOPWATCH_LAP_EN only)
//   bcd_digits  out  [3:0] hundredths, [7:4] tenths, [11:8] s units, [15:12] s tens
//   running     out  high while the state machine is in RUN
//   overflow    out  sticky; set when the count wraps from 99.99 to 00.00

// Key conditioning.
// The key passes through a 2-FF synchroniser and a level debouncer. The
// module emits a single-cycle press pulse on a debounced 1->0 edge. A key
// release produces no pulse.
// After reset, the key is not armed. It arms only once the key has been
// seen released for DEB_CNT cycles. This stops a key held through reset
// from being taken as a press.
module stopwatch_key_deb #(
  parameter int unsigned DEB_CNT = 240000
) (
  input  logic clk_24m,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int unsigned CW = $clog2(DEB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync1, sync2, deb, deb_d, armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      deb_d <= deb;
      press <= armed & deb_d & ~deb;
      if (!armed) begin
        // Wait for a qualified release before any press can count.
        if (sync2) begin
          if (cnt == CNT_LAST) begin
            armed <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end else if (sync2 != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module stopwatch_bcd_ctrl #(
  parameter int unsigned TICK_DIV = 240000,
  parameter int unsigned DEB_CNT  = 240000
) (
  input  logic        clk_24m,
  input  logic        rst_n,
  input  logic        key_start_n,
  input  logic        key_clr_n,
`ifdef STOPWATCH_LAP_EN
  input  logic        key_lap_n,
`endif
  output logic [15:0] bcd_digits,
  output logic        running,
  output logic        overflow
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic [16:0]   count_inc;
  logic          start_ev, clr_ev, tick;

  // Ripple the +1 from the hundredths digit upward. Returns {carry_out, digits}.
  // A carry out of the tens-of-seconds digit marks the wrap from 99.99.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  stopwatch_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_start (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .key_n   (key_start_n),
    .press   (start_ev)
  );

  stopwatch_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_clr (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .key_n   (key_clr_n),
    .press   (clr_ev)
  );

  assign tick      = (state == ST_RUN) && (presc == PRESC_LAST);
  assign count_inc = bcd_inc(count);

`ifdef STOPWATCH_LAP_EN
  logic        lap_ev, frozen;
  logic [15:0] snap;

  stopwatch_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_lap (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .key_n   (key_lap_n),
    .press   (lap_ev)
  );

  assign bcd_digits = frozen ? snap : count;
`else
  assign bcd_digits = count;
`endif

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
      presc    <= '0;
      count    <= '0;
`ifdef STOPWATCH_LAP_EN
      frozen   <= 1'b0;
      snap     <= '0;
`endif
    end else if (clr_ev) begin
      // Clear wins over a simultaneous start press.
      state    <= ST_IDLE;
      running  <= 1'b0;
      overflow <= 1'b0;
      presc    <= '0;
      count    <= '0;
`ifdef STOPWATCH_LAP_EN
      frozen   <= 1'b0;
`endif
    end else begin
      if (start_ev) begin
        case (state)
          ST_IDLE:  begin state <= ST_RUN;   running <= 1'b1; end
          ST_RUN:   begin state <= ST_PAUSE; running <= 1'b0; end
          ST_PAUSE: begin state <= ST_RUN;   running <= 1'b1; end
          default:  begin state <= ST_IDLE;  running <= 1'b0; end
        endcase
      end
      // The prescaler holds in PAUSE so a resume finishes the partial tick.
      if (state == ST_RUN) begin
        if (tick) begin
          presc <= '0;
          count <= count_inc[15:0];
          if (count_inc[16]) overflow <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end else if (state == ST_IDLE) begin
        presc <= '0;
      end
`ifdef STOPWATCH_LAP_EN
      // The snapshot is the value on display when the lap press lands.
      if (lap_ev && (state == ST_RUN)) begin
        frozen <= ~frozen;
        if (!frozen) snap <= count;
      end
`endif
    end
  end
endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// Directed testbench for stopwatch_bcd_ctrl with TICK_DIV=4 and DEB_CNT=8.
// Inputs are driven and outputs are sampled on the falling clock edge.
// With these settings, a clean key fall lands in the state machine 12 rising
// edges later. Each count tick is 4 cycles apart while running.
module tb_stopwatch_bcd_ctrl;
  logic        clk_24m;
  logic        rst_n;
  logic        key_start_n;
  logic        key_clr_n;
`ifdef STOPWATCH_LAP_EN
  logic        key_lap_n;
`endif
  logic [15:0] bcd_digits;
  logic        running;
  logic        overflow;

  int cmp_cnt = 0;
  int err_cnt = 0;

  stopwatch_bcd_ctrl #(.TICK_DIV(4), .DEB_CNT(8)) dut (
    .clk_24m     (clk_24m),
    .rst_n       (rst_n),
    .key_start_n (key_start_n),
    .key_clr_n   (key_clr_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n   (key_lap_n),
`endif
    .bcd_digits  (bcd_digits),
    .running     (running),
    .overflow    (overflow)
  );

  // Clock and reset
  initial clk_24m = 1'b0;
  always #5 clk_24m = ~clk_24m;

  initial begin
    rst_n       = 1'b0;
    key_start_n = 1'b1;
    key_clr_n   = 1'b1;
`ifdef STOPWATCH_LAP_EN
    key_lap_n   = 1'b1;
`endif
  end

  // Reference model: a decimal tick count rendered as 4 BCD digits.
  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    key_start_n = 1'b1;
    key_clr_n   = 1'b1;
`ifdef STOPWATCH_LAP_EN
    key_lap_n   = 1'b1;
`endif
    repeat (3) @(negedge clk_24m);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_24m);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24m);
      cmp_cnt++;
      if (bcd_digits !== 16'h0000) begin
        err_cnt++;
        $display("FAIL reset_bcd cycle %0d: got %h expected 0000", i, bcd_digits);
      end
      cmp_cnt++;
      if (running !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_running cycle %0d: got %b expected 0", i, running);
      end
      cmp_cnt++;
      if (overflow !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_overflow cycle %0d: got %b expected 0", i, overflow);
      end
    end
  endtask

  task automatic test_start_latency();
    do_reset();
    key_start_n = 1'b0;
    for (int i = 1; i <= 52; i++) begin
      @(negedge clk_24m);
      if (i == 30) key_start_n = 1'b1;
      if (i == 11) begin
        cmp_cnt++;
        if (running !== 1'b0) begin
          err_cnt++;
          $display("FAIL start_early: got running=%b expected 0", running);
        end
      end
      if (i == 12) begin
        cmp_cnt++;
        if (running !== 1'b1) begin
          err_cnt++;
          $display("FAIL start_latency: got running=%b expected 1", running);
        end
      end
      if (i == 51) begin
        cmp_cnt++;
        if (bcd_digits !== 16'h0009) begin
          err_cnt++;
          $display("FAIL count_9: got %h expected 0009", bcd_digits);
        end
      end
      if (i == 52) begin
        cmp_cnt++;
        if (bcd_digits !== 16'h0010) begin
          err_cnt++;
          $display("FAIL count_10: got %h expected 0010", bcd_digits);
        end
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      key_start_n = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      @(negedge clk_24m);
    end
    key_start_n = 1'b1;
    repeat (30) @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b0) begin
      err_cnt++;
      $display("FAIL bounce_running: got %b expected 0", running);
    end
    cmp_cnt++;
    if (bcd_digits !== 16'h0000) begin
      err_cnt++;
      $display("FAIL bounce_bcd: got %h expected 0000", bcd_digits);
    end
  endtask

  // Full run through 99.99. The bench checks every displayed change against
  // the model, then the wrap and the sticky overflow. A start press then
  // pauses the count.
  task automatic test_wrap_pause();
    logic [15:0] prev;
    int          n;
    bit          done;
    do_reset();
    prev = 16'h0000;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 45000 && !done; c++) begin
      if (c == 0)  key_start_n = 1'b0;
      if (c == 15) key_start_n = 1'b1;
      @(negedge clk_24m);
      if (bcd_digits !== prev) begin
        n++;
        cmp_cnt++;
        if (bcd_digits !== to_bcd(n % 10000)) begin
          err_cnt++;
          $display("FAIL count_step %0d: got %h expected %h", n, bcd_digits, to_bcd(n % 10000));
        end
        if (n == 9999) begin
          cmp_cnt++;
          if (overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL overflow_early: got %b expected 0", overflow);
          end
        end
        if (n == 10000) begin
          done = 1'b1;
          cmp_cnt++;
          if (overflow !== 1'b1) begin
            err_cnt++;
            $display("FAIL wrap_overflow: got %b expected 1", overflow);
          end
          cmp_cnt++;
          if (running !== 1'b1) begin
            err_cnt++;
            $display("FAIL wrap_running: got %b expected 1", running);
          end
        end
        prev = bcd_digits;
      end
    end
    if (!done) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL wrap_timeout: reached %0d ticks, required 10000", n);
    end
    // The pause lands 12 edges after the wrap tick. Ticks at +4, +8 and +12
    // still count, so 00.03 is held.
    key_start_n = 1'b0;
    repeat (12) @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b0) begin
      err_cnt++;
      $display("FAIL pause_running: got %b expected 0", running);
    end
    cmp_cnt++;
    if (overflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL pause_overflow: got %b expected 1", overflow);
    end
    repeat (3) @(negedge clk_24m);
    key_start_n = 1'b1;
    repeat (30) @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0003) begin
      err_cnt++;
      $display("FAIL pause_hold: got %h expected 0003", bcd_digits);
    end
  endtask

  // Resume from pause, then press start and clear together at 01.23.
  task automatic test_start_clr_same_cycle();
    bit found;
    found = 1'b0;
    key_start_n = 1'b0;
    repeat (15) @(negedge clk_24m);
    key_start_n = 1'b1;
    cmp_cnt++;
    if (running !== 1'b1) begin
      err_cnt++;
      $display("FAIL resume_running: got %b expected 1", running);
    end
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk_24m);
      if (bcd_digits === 16'h0123) found = 1'b1;
    end
    if (!found) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL reach_0123_timeout: got %h expected 0123", bcd_digits);
    end
    key_start_n = 1'b0;
    key_clr_n   = 1'b0;
    repeat (11) @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b1) begin
      err_cnt++;
      $display("FAIL clr_early: got running=%b expected 1", running);
    end
    @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_running: got %b expected 0", running);
    end
    cmp_cnt++;
    if (bcd_digits !== 16'h0000) begin
      err_cnt++;
      $display("FAIL clr_bcd: got %h expected 0000", bcd_digits);
    end
    cmp_cnt++;
    if (overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_overflow: got %b expected 0", overflow);
    end
    repeat (3) @(negedge clk_24m);
    key_start_n = 1'b1;
    key_clr_n   = 1'b1;
    repeat (20) @(negedge clk_24m);
  endtask

  // After clear, a fresh start counts from 00.00 with a fresh prescaler.
  task automatic test_back_to_back();
    key_start_n = 1'b0;
    repeat (12) @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b1) begin
      err_cnt++;
      $display("FAIL restart_running: got %b expected 1", running);
    end
    repeat (3) @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0000) begin
      err_cnt++;
      $display("FAIL restart_pre_tick: got %h expected 0000", bcd_digits);
    end
    @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0001) begin
      err_cnt++;
      $display("FAIL restart_first_tick: got %h expected 0001", bcd_digits);
    end
    key_start_n = 1'b1;
    repeat (20) @(negedge clk_24m);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk_24m);
    #2;
    rst_n       = 1'b0;
    key_start_n = 1'b0;
    #1;
    cmp_cnt++;
    if (bcd_digits !== 16'h0000) begin
      err_cnt++;
      $display("FAIL async_reset_bcd: got %h expected 0000", bcd_digits);
    end
    cmp_cnt++;
    if (running !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset_running: got %b expected 0", running);
    end
    repeat (3) @(negedge clk_24m);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b0) begin
      err_cnt++;
      $display("FAIL held_key_ignored: got running=%b expected 0", running);
    end
    key_start_n = 1'b1;
    repeat (30) @(negedge clk_24m);
    key_start_n = 1'b0;
    repeat (12) @(negedge clk_24m);
    cmp_cnt++;
    if (running !== 1'b1) begin
      err_cnt++;
      $display("FAIL repress_after_reset: got running=%b expected 1", running);
    end
    repeat (3) @(negedge clk_24m);
    key_start_n = 1'b1;
    repeat (20) @(negedge clk_24m);
  endtask

`ifdef STOPWATCH_LAP_EN
  // k counts falling edges after the tick that shows 00.47. The ticks land
  // on rising edges k = 4, 8, 12, and so on.
  task automatic test_lap();
    bit found;
    do_reset();
    found = 1'b0;
    key_start_n = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (c == 15) key_start_n = 1'b1;
      @(negedge clk_24m);
      if (bcd_digits === 16'h0047) found = 1'b1;
    end
    key_start_n = 1'b1;
    if (!found) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL reach_0047_timeout: got %h expected 0047", bcd_digits);
    end
    @(negedge clk_24m);
    key_lap_n = 1'b0;
    repeat (12) @(negedge clk_24m);
    @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0050) begin
      err_cnt++;
      $display("FAIL lap_snapshot: got %h expected 0050", bcd_digits);
    end
    repeat (2) @(negedge clk_24m);
    key_lap_n = 1'b1;
    repeat (78) @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0050) begin
      err_cnt++;
      $display("FAIL lap_hold: got %h expected 0050", bcd_digits);
    end
    cmp_cnt++;
    if (running !== 1'b1) begin
      err_cnt++;
      $display("FAIL lap_running: got %b expected 1", running);
    end
    key_lap_n = 1'b0;
    repeat (11) @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0050) begin
      err_cnt++;
      $display("FAIL lap_hold_late: got %h expected 0050", bcd_digits);
    end
    @(negedge clk_24m);
    cmp_cnt++;
    if (bcd_digits !== 16'h0073) begin
      err_cnt++;
      $display("FAIL lap_release_live: got %h expected 0073", bcd_digits);
    end
    repeat (3) @(negedge clk_24m);
    key_lap_n = 1'b1;
    repeat (20) @(negedge clk_24m);
  endtask
`endif

  initial begin
    test_reset();
    test_start_latency();
    test_bounce();
    test_wrap_pause();
    test_start_clr_same_cycle();
    test_back_to_back();
    test_reset_midrun();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
